// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the multi-channel FIFO pointer controller.
// Flag bundle is width-independent, so every channel instance shares one struct.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_CHANNELS   = 4;

  // Pointer carries one extra wrap bit above the RAM address bits.
  typedef logic [DEF_ADDR_WIDTH:0] fifo_ptr_t;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_flags_t;

  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int chan_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/fifo_channel_state.sv
// Per-channel pointer/error state with registered flag and occupancy decode.
// Flags change one cycle after the accepting edge; no backpressure of its own.
module fifo_channel_state
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_TH      = (2 ** DEF_ADDR_WIDTH) - 2,
  parameter int AE_TH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_inc_i,
  input  logic                  rd_inc_i,
  input  logic                  wr_err_i,
  input  logic                  rd_err_i,
  input  logic                  flush_i,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output fifo_flags_t           flags_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int PW = count_width(ADDR_WIDTH);
  localparam logic [PW-1:0] AF_C = PW'(AF_TH);
  localparam logic [PW-1:0] AE_C = PW'(AE_TH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  // Flush wins over any access or error to this channel in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_inc_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_inc_i) rd_ptr_d = rd_ptr_q + PW'(1);
      if (wr_err_i) ovf_d = 1'b1;
      if (rd_err_i) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign wr_addr_o   = wr_ptr_q[ADDR_WIDTH-1:0];
  assign rd_addr_o   = rd_ptr_q[ADDR_WIDTH-1:0];
  assign count_o     = wr_ptr_q - rd_ptr_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;

  always_comb begin
    flags_o              = '0;
    flags_o.empty        = (wr_ptr_q == rd_ptr_q);
    flags_o.full         = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                           (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    flags_o.almost_empty = (count_o <= AE_C);
    flags_o.almost_full  = (count_o >= AF_C);
  end

endmodule

// File: rtl/multi_fifo_controller.sv
// Pointer/flag controller for CHANNELS circular FIFOs in one shared RAM; addresses and accepts are
// combinational, flags/counts lag one cycle. Full/empty/flushed channels reject and never stall.
module multi_fifo_controller
  import fifo_pkg::*;
#(
  parameter int  ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int  CHANNELS        = DEF_CHANNELS,
  parameter int  ALMOST_FULL_TH  = (2 ** ADDR_WIDTH) - 2,
  parameter int  ALMOST_EMPTY_TH = 2,
  localparam int CH_W            = $clog2(CHANNELS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              write_enable,
  input  logic [CH_W-1:0]                   write_channel,
  input  logic                              read_enable,
  input  logic [CH_W-1:0]                   read_channel,
  input  logic [CHANNELS-1:0]               flush,
  output logic [CH_W+ADDR_WIDTH-1:0]        write_addr,
  output logic [CH_W+ADDR_WIDTH-1:0]        read_addr,
  output logic                              write_accept,
  output logic                              read_accept,
  output logic [CHANNELS-1:0]               empty,
  output logic [CHANNELS-1:0]               full,
  output logic [CHANNELS-1:0]               almost_empty,
  output logic [CHANNELS-1:0]               almost_full,
  output logic [CHANNELS*(ADDR_WIDTH+1)-1:0] count,
  output logic [CHANNELS-1:0]               overflow,
  output logic [CHANNELS-1:0]               underflow
);

  localparam int CW = count_width(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_addr_lo [CHANNELS];
  logic [ADDR_WIDTH-1:0] rd_addr_lo [CHANNELS];
  logic [CHANNELS-1:0]   wr_inc, rd_inc, wr_err, rd_err;

  // Acceptance looks only at start-of-cycle flags, so a same-cycle read never frees a full slot.
  assign write_accept = write_enable & ~full[write_channel]  & ~flush[write_channel];
  assign read_accept  = read_enable  & ~empty[read_channel]  & ~flush[read_channel];

  assign write_addr = {write_channel, wr_addr_lo[write_channel]};
  assign read_addr  = {read_channel,  rd_addr_lo[read_channel]};

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic          sel_w, sel_r;
    logic [CW-1:0] cnt;
    fifo_flags_t   flg;

    assign sel_w     = (write_channel == CH_W'(g));
    assign sel_r     = (read_channel  == CH_W'(g));
    assign wr_inc[g] = write_accept & sel_w;
    assign rd_inc[g] = read_accept  & sel_r;
    assign wr_err[g] = write_enable & sel_w & full[g];
    assign rd_err[g] = read_enable  & sel_r & empty[g];

    fifo_channel_state #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .AF_TH      (ALMOST_FULL_TH),
      .AE_TH      (ALMOST_EMPTY_TH)
    ) u_state (
      .clk         (clk),
      .reset       (reset),
      .wr_inc_i    (wr_inc[g]),
      .rd_inc_i    (rd_inc[g]),
      .wr_err_i    (wr_err[g]),
      .rd_err_i    (rd_err[g]),
      .flush_i     (flush[g]),
      .wr_addr_o   (wr_addr_lo[g]),
      .rd_addr_o   (rd_addr_lo[g]),
      .count_o     (cnt),
      .flags_o     (flg),
      .overflow_o  (overflow[g]),
      .underflow_o (underflow[g])
    );

    assign empty[g]          = flg.empty;
    assign full[g]           = flg.full;
    assign almost_empty[g]   = flg.almost_empty;
    assign almost_full[g]    = flg.almost_full;
    assign count[g*CW +: CW] = cnt;
  end

endmodule

// File: doc/multi_fifo_controller.md
# multi_fifo_controller

Pointer and flag controller for up to CHANNELS independent circular FIFOs sharing one external RAM. Each channel owns a 2^ADDR_WIDTH-entry region addressed as {channel, pointer}. The block generates write/read RAM addresses, per-channel full/empty/almost flags, occupancy counts, flush and sticky overflow/underflow errors. It sits between the layer-sequencer producers/consumers and the shared activation/weight buffer RAM, replacing single-queue controllers where several streams are buffered at once.

## Interface
- ADDR_WIDTH, 4: per-channel pointer width; capacity = 2^ADDR_WIDTH entries per channel (all slots usable).
- CHANNELS, 4: number of FIFOs; must be ≥2.
- ALMOST_FULL_TH, 2^ADDR_WIDTH-2: almost_full asserted when count ≥ this.
- ALMOST_EMPTY_TH, 2: almost_empty asserted when count ≤ this.
- CH_W (localparam): $clog2(CHANNELS).

Ports:
- clk  in  1  clock; all state on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- write_enable  in  1  write request.
- write_channel  in  CH_W  target channel of write.
- read_enable  in  1  read request.
- read_channel  in  CH_W  source channel of read.
- flush  in  CHANNELS  per-channel flush mask.
- write_addr  out  CH_W+ADDR_WIDTH  {write_channel, wr_ptr[write_channel]}, combinational.
- read_addr  out  CH_W+ADDR_WIDTH  {read_channel, rd_ptr[read_channel]}, combinational.
- write_accept  out  1  write_enable & ~full[write_channel] & ~flush[write_channel].
- read_accept  out  1  read_enable & ~empty[read_channel] & ~flush[read_channel].
- empty, full, almost_empty, almost_full  out  CHANNELS each  per-channel flags.
- count  out  CHANNELS*(ADDR_WIDTH+1)  packed occupancy, channel 0 in LSBs.
- overflow, underflow  out  CHANNELS each  sticky error flags.

## Operation
- Per channel: wr_ptr, rd_ptr of ADDR_WIDTH+1 bits (MSB = wrap bit). empty = ptrs equal; full = low bits equal, wrap bits differ. count = wr_ptr − rd_ptr modulo 2^(ADDR_WIDTH+1).
- Accepted write: wr_ptr[ch] += 1. Accepted read: rd_ptr[ch] += 1. Pointers wrap naturally; RAM address uses low ADDR_WIDTH bits.
- Simultaneous write and read, different channels: both proceed independently.
- Same channel: each accepted based on flags at start of cycle. Full ⇒ write rejected even if a read is accepted that cycle. Empty ⇒ read rejected even if a write is accepted. Otherwise both advance, count unchanged.
- Rejected write (enable & full) sets overflow[ch]. Rejected read (enable & empty) sets underflow[ch]. Sticky until reset or flush of that channel. Writes/reads rejected by flush set no error.
- flush[ch]: next edge sets wr_ptr = rd_ptr = 0 and clears both errors for ch. Overrides any write/read to ch that cycle. Other channels unaffected.
- reset: all pointers 0, all errors 0. Reset overrides flush and accesses.

## Timing
- Reset values: empty all 1, almost_empty all 1, full 0, almost_full 0 (given TH > 0), count 0, overflow/underflow 0. write_addr/read_addr = {channel input, 0}. Accepts follow the combinational definitions.
- Flags, count and errors are decoded from registered state only, with no input-to-flag paths. A change becomes visible the cycle after the accepting edge.
- write_addr/read_addr/accepts are combinational from channel inputs and current pointers. The RAM write uses write_addr in the same cycle as write_accept. Read data latency is owned by the RAM (1 cycle for the standard buffer).
- Back-to-back accesses every cycle are supported. Throughput is 1 write + 1 read per cycle.
- Reset asserted mid-stream discards all contents at that edge. First access is allowed the cycle after reset deasserts.

## Structure
- Package fifo_pkg: fifo_ptr_t and count width helpers parametrised via localparams; shared flag struct fifo_flags_t {empty, full, almost_empty, almost_full}.
- Sub-module fifo_channel_state: one per channel via generate. Holds pointers, error bits, flag/count decode. Inputs wr_inc, rd_inc, flush. The top does channel decode, accept logic and address muxing.

## Test plan
- Reset, then write 16 to ch1 (ADDR_WIDTH=4) → write_addr 0x10..0x1F. full[1]=1 after 16th. count[1]=16. 17th write_enable → write_accept=0, overflow[1]=1.
- Read ch1 ×16 → read_addr 0x10..0x1F, then empty[1]=1. Extra read → underflow[1]=1. Then write 20/read 20 interleaved → addresses wrap 0x1F→0x10, no errors.
- Same-cycle write+read ch2 at count 5 → count stays 5. At full (16) → only read accepted, count 15, overflow[2]=1. At empty → only write accepted, count 1, underflow[2]=1.
- Write ch0 while reading ch3 each cycle → independent counts. almost_full[0] at count 14. almost_empty[3] at count ≤2.
- flush[1] concurrent with write to ch1 at count 9 → next cycle count[1]=0, empty[1]=1, errors cleared, write not accepted. Other channels' counts unchanged.
- reset asserted while ch0 count=7 and write_enable high → next cycle all counts 0, all flags at reset values.
